// File: rtl/ex_mem_skid_reg_if.sv
// rtl/ex_mem_skid_reg_if.sv - EX/MEM pipeline register handshake and payload bundle
// Purpose: groups the flush, upstream (EX) and downstream (MEM) handshake and
// payload signals of the EX/MEM skid register.
// Ports (signals):
//   Flush                     discard all held and incoming entries
//   InValid / InReady         EX-side handshake
//   InCtrl, InBranchTarget, InALU, InWriteData, InZero, InDestReg   EX payload
//   OutValid / OutReady       MEM-side handshake
//   OutCtrl, OutBranchTarget, OutALU, OutWriteData, OutZero, OutDestReg  MEM payload
// Modports: master = pipeline control/environment view, slave = the register.
interface ex_mem_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 5
);
    logic              Flush;
    logic              InValid;
    logic              InReady;
    logic [CTRL_W-1:0] InCtrl;
    logic [DATA_W-1:0] InBranchTarget;
    logic [DATA_W-1:0] InALU;
    logic [DATA_W-1:0] InWriteData;
    logic              InZero;
    logic [REG_W-1:0]  InDestReg;
    logic              OutValid;
    logic              OutReady;
    logic [CTRL_W-1:0] OutCtrl;
    logic [DATA_W-1:0] OutBranchTarget;
    logic [DATA_W-1:0] OutALU;
    logic [DATA_W-1:0] OutWriteData;
    logic              OutZero;
    logic [REG_W-1:0]  OutDestReg;

    modport master (
        output Flush, InValid, InCtrl, InBranchTarget, InALU, InWriteData, InZero, InDestReg,
        output OutReady,
        input  InReady, OutValid, OutCtrl, OutBranchTarget, OutALU, OutWriteData, OutZero, OutDestReg
    );

    modport slave (
        input  Flush, InValid, InCtrl, InBranchTarget, InALU, InWriteData, InZero, InDestReg,
        input  OutReady,
        output InReady, OutValid, OutCtrl, OutBranchTarget, OutALU, OutWriteData, OutZero, OutDestReg
    );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - two-entry skid buffer acting as the EX/MEM pipeline register
// Purpose: holds up to two EX results (main + skid) in strict FIFO order so that
// InReady depends only on registered state, never on OutReady.
// Ports:
//   Clk  single clock, all state changes on its rising edge
//   Rst  synchronous active-high reset
//   bus  ex_mem_skid_reg_if.slave: Flush, In* handshake/payload, Out* handshake/payload
// Out* always shows the main entry; OutCtrl reads zero whenever OutValid is low.
module ex_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    ex_mem_skid_reg_if.slave  bus
);
    localparam int ENT_W    = CTRL_W + 3 * DATA_W + REG_W + 1;
    // Field offsets inside a packed entry, LSB first.
    localparam int ZERO_OFS = REG_W;
    localparam int WD_OFS   = REG_W + 1;
    localparam int ALU_OFS  = WD_OFS + DATA_W;
    localparam int BT_OFS   = ALU_OFS + DATA_W;
    localparam int CTRL_OFS = BT_OFS + DATA_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ENT_W-1:0] main_q, main_d;
    logic [ENT_W-1:0] skid_q, skid_d;
    logic [ENT_W-1:0] in_ent;
    logic             accept;
    logic             consume;

    assign in_ent = {bus.InCtrl, bus.InBranchTarget, bus.InALU, bus.InWriteData,
                     bus.InZero, bus.InDestReg};

    // Ready comes from registered state only; Rst gating keeps it low during reset.
    assign bus.InReady  = (state_q != ST_FULL) && !Rst;
    assign bus.OutValid = (state_q == ST_ONE) || (state_q == ST_FULL);

    assign accept  = bus.InValid && bus.InReady;
    assign consume = bus.OutValid && bus.OutReady;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.Flush) begin
            // Flush wins over any same-cycle accept/consume; only control bits
            // are cleared so the bubble carries no side effects downstream.
            state_d                        = ST_EMPTY;
            main_d[CTRL_OFS +: CTRL_W]     = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_ent;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_d = in_ent;
                    end else if (accept) begin
                        skid_d  = in_ent;
                        state_d = ST_FULL;
                    end else if (consume) begin
                        main_d[CTRL_OFS +: CTRL_W] = '0;
                        state_d                    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    main_d[CTRL_OFS +: CTRL_W] = '0;
                    state_d                    = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.OutDestReg      = main_q[REG_W-1:0];
    assign bus.OutZero         = main_q[ZERO_OFS];
    assign bus.OutWriteData    = main_q[WD_OFS +: DATA_W];
    assign bus.OutALU          = main_q[ALU_OFS +: DATA_W];
    assign bus.OutBranchTarget = main_q[BT_OFS +: DATA_W];
    assign bus.OutCtrl         = main_q[CTRL_OFS +: CTRL_W];
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb/tb_ex_mem_skid_reg.sv - scoreboard bench for the EX/MEM skid register
module tb_ex_mem_skid_reg;
    typedef struct packed {
        logic [4:0]  ctrl;
        logic [31:0] bt;
        logic [31:0] alu;
        logic [31:0] wd;
        logic        zero;
        logic [4:0]  dest;
    } ent_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    ex_mem_skid_reg_if #(.DATA_W(32), .REG_W(5), .CTRL_W(5)) bus ();

    ex_mem_skid_reg #(.DATA_W(32), .REG_W(5), .CTRL_W(5)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cnt   = 0;      // model occupancy
    ent_t sb[$];          // entries accepted but not yet consumed, oldest first

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] alu, input logic [31:0] c, input logic [31:0] d);
        ent_t e;
        logic [31:0] r;
        e.ctrl = c[4:0];
        e.bt   = $urandom;
        e.alu  = alu;
        e.wd   = $urandom;
        r      = $urandom;
        e.zero = r[0];
        e.dest = d[4:0];
        return e;
    endfunction

    // One clock of stimulus: drive at negedge+1, update the model at negedge+2,
    // then check occupancy-derived outputs at the following negedge+1.
    task automatic step(input ent_t p, input logic v, input logic ordy, input logic fl,
                        input logic rs, output logic acc);
        logic cons;
        bus.InValid = v;
        {bus.InCtrl, bus.InBranchTarget, bus.InALU, bus.InWriteData, bus.InZero, bus.InDestReg} = p;
        bus.OutReady = ordy;
        bus.Flush    = fl;
        Rst          = rs;
        #1;
        acc  = bus.InValid && bus.InReady;
        cons = bus.OutValid && bus.OutReady;
        if (rs || fl) begin
            cnt = 0;
            sb.delete();
        end else begin
            if (acc) sb.push_back(p);
            cnt = cnt + int'(acc) - int'(cons);
        end
        @(negedge Clk);
        #1;
        chk("out_valid", bus.OutValid, cnt > 0);
        chk("in_ready", bus.InReady, (cnt < 2) && !rs);
        if (!bus.OutValid) chk("bubble_ctrl", bus.OutCtrl, 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctrl"}, bus.OutCtrl, 0);
        chk({nm, "_bt"},   bus.OutBranchTarget, 0);
        chk({nm, "_alu"},  bus.OutALU, 0);
        chk({nm, "_wd"},   bus.OutWriteData, 0);
        chk({nm, "_zero"}, bus.OutZero, 0);
        chk({nm, "_dest"}, bus.OutDestReg, 0);
    endtask

    // Monitor: just before each posedge, a consumed head must match the oldest entry.
    initial begin
        ent_t e, o;
        forever begin
            @(negedge Clk);
            #3;
            if (!Rst && !bus.Flush && bus.OutValid && bus.OutReady) begin
                o = {bus.OutCtrl, bus.OutBranchTarget, bus.OutALU, bus.OutWriteData,
                     bus.OutZero, bus.OutDestReg};
                if (sb.size() == 0) begin
                    chk("unexpected_out", o, 0);
                end else begin
                    e = sb.pop_front();
                    chk("payload", o, e);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t idle;
        ent_t cur;
        logic acc;
        logic cv;
        idle = '0;
        bus.Flush = 1'b0; bus.InValid = 1'b0; bus.OutReady = 1'b0;
        {bus.InCtrl, bus.InBranchTarget, bus.InALU, bus.InWriteData, bus.InZero, bus.InDestReg} = '0;
        @(negedge Clk);
        #1;

        // Reset state, then ready in the first cycle after reset drops
        step(idle, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        step(mk(32'h77, 32'h1f, 3), 1'b1, 1'b0, 1'b0, 1'b1, acc);
        chk_zero("reset");
        step(idle, 1'b0, 1'b0, 1'b0, 1'b0, acc);

        // First transaction latency
        step(mk(32'h0000_00A5, 32'b01000, 9), 1'b1, 1'b1, 1'b0, 1'b0, acc);
        chk("lat_alu", bus.OutALU, 32'hA5);
        chk("lat_ctrl", bus.OutCtrl, 5'b01000);
        chk("lat_dest", bus.OutDestReg, 9);
        step(idle, 1'b0, 1'b1, 1'b0, 1'b0, acc);

        // Full-rate streaming
        for (int i = 1; i <= 4; i++) begin
            step(mk(i, 32'h8, i), 1'b1, 1'b1, 1'b0, 1'b0, acc);
            chk("stream_alu", bus.OutALU, i);
        end
        step(idle, 1'b0, 1'b1, 1'b0, 1'b0, acc);

        // Backpressure: fill, hold third, then drain in order
        step(mk(32'h10, 32'h2, 1), 1'b1, 1'b0, 1'b0, 1'b0, acc);
        step(mk(32'h20, 32'h2, 2), 1'b1, 1'b0, 1'b0, 1'b0, acc);
        cur = mk(32'h30, 32'h2, 3);
        step(cur, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        chk("full_no_accept", acc, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(cur, 1'b1, 1'b1, 1'b0, 1'b0, acc);
            if (acc) break;
        end
        chk("held_accepted", acc, 1'b1);
        for (int k = 0; k < 3; k++) step(idle, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        chk("bp_drained", sb.size(), 0);

        // Flush while full with a valid input
        step(mk(32'h41, 32'h8, 1), 1'b1, 1'b0, 1'b0, 1'b0, acc);
        step(mk(32'h42, 32'h8, 2), 1'b1, 1'b0, 1'b0, 1'b0, acc);
        step(mk(32'h99, 32'h1f, 7), 1'b1, 1'b0, 1'b1, 1'b0, acc);
        chk("flush_ctrl", bus.OutCtrl, 0);
        for (int k = 0; k < 2; k++) step(idle, 1'b0, 1'b1, 1'b0, 1'b0, acc);

        // Reset while full
        step(mk(32'h51, 32'h1f, 1), 1'b1, 1'b0, 1'b0, 1'b0, acc);
        step(mk(32'h52, 32'h1f, 2), 1'b1, 1'b0, 1'b0, 1'b0, acc);
        step(idle, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        chk_zero("midrst");
        step(idle, 1'b0, 1'b0, 1'b0, 1'b0, acc);

        // Simultaneous accept and consume in ONE
        step(mk(32'h5, 32'h8, 5), 1'b1, 1'b0, 1'b0, 1'b0, acc);
        step(mk(32'h6, 32'h8, 6), 1'b1, 1'b1, 1'b0, 1'b0, acc);
        chk("ac_alu", bus.OutALU, 32'h6);
        step(idle, 1'b0, 1'b1, 1'b0, 1'b0, acc);

        // Randomized traffic; source holds payload while stalled
        cv = 1'b0; cur = idle; acc = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if (!(cv && !acc)) begin
                cv  = ($urandom_range(0, 3) != 0);
                cur = mk($urandom, $urandom, $urandom);
            end
            step(cur, cv, ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 59) == 0), acc);
        end
        for (int k = 0; k < 3; k++) step(idle, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        chk("final_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_mem_skid_reg.md
EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the branch-target, ALU-result and store-data fields.
REQ-002 Parameter REG_W, default 5: width of the destination-register field.
REQ-003 Parameter CTRL_W, default 5: control-bit vector width; bit0 Branch, bit1 MemRead, bit2 MemWrite, bit3 RegWrite, bit4 MemToReg, higher bits user-defined.
REQ-004 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-005 Rst  in  1  reset, synchronous, active-high.
REQ-006 Flush  in  1  discard all held and incoming entries.
REQ-007 InValid  in  1  EX stage presents a valid entry.
REQ-008 InReady  out  1  block can accept an entry this cycle.
REQ-009 InCtrl  in  CTRL_W  control bits; InBranchTarget, InALU, InWriteData  in  DATA_W each; InZero  in  1; InDestReg  in  REG_W.
REQ-010 OutValid  out  1  MEM-stage entry valid.
REQ-011 OutReady  in  1  MEM stage consumes the head entry this cycle.
REQ-012 OutCtrl  out  CTRL_W; OutBranchTarget, OutALU, OutWriteData  out  DATA_W each; OutZero  out  1; OutDestReg  out  REG_W; all registered, mirroring the In fields.

Function
REQ-013 Storage: two-entry skid buffer (main, skid), each entry holding the full payload (CTRL_W+3*DATA_W+REG_W+1 bits), strict FIFO order.
REQ-014 States: EMPTY (0 entries), ONE (main only), FULL (main+skid); state held in registers.
REQ-015 Accept = InValid && InReady; Consume = OutValid && OutReady.
REQ-016 InReady = 1 in EMPTY and ONE, 0 in FULL; derived from registered state only (no combinational path from OutReady to InReady).
REQ-017 OutValid = 1 in ONE and FULL, 0 in EMPTY; Out* fields always show the main entry.
REQ-018 EMPTY: Accept -> ONE, payload into main; else stay.
REQ-019 ONE: Accept&&Consume -> ONE, main replaced by input; Accept only -> FULL, input into skid; Consume only -> EMPTY; neither -> hold.
REQ-020 FULL: Consume -> ONE, skid moves to main; else hold (no Accept possible).
REQ-021 Latency: an entry accepted in EMPTY appears on Out* with OutValid=1 the next cycle.
REQ-022 Throughput: with OutReady held 1, one entry per cycle, state never leaves ONE after first accept.
REQ-023 Bubble: when OutValid=0, OutCtrl SHALL read all zeros; data fields hold their last value.
REQ-024 Flush=1 at a posedge: next state EMPTY, OutCtrl cleared, any same-cycle Accept discarded; InReady still follows REQ-016 during the flush cycle.
REQ-025 Priority at a posedge: Rst > Flush > Accept/Consume.
REQ-026 Entries are never duplicated or dropped except by Flush or Rst; an entry leaves only on Consume.
REQ-027 InValid while InReady=0 has no effect; upstream must hold its payload.

Reset
REQ-028 Rst sampled high at posedge: state EMPTY, OutValid=0, OutCtrl=0, OutBranchTarget=0, OutALU=0, OutZero=0, OutWriteData=0, OutDestReg=0, skid entry cleared.
REQ-029 InReady SHALL be 0 while Rst is high and 1 in the first cycle after Rst deasserts.
REQ-030 Rst asserted mid-operation (ONE or FULL) discards all entries identically to REQ-028.

Verification
REQ-031 Reset then InValid=1, InALU=0x0000_00A5, InCtrl=5'b01000, InDestReg=9, OutReady=1 -> next cycle OutValid=1, OutALU=0x000000A5, OutCtrl=5'b01000, OutDestReg=9.
REQ-032 Stream ALU=1,2,3,4 on consecutive cycles with OutReady=1 -> Out shows 1,2,3,4 on consecutive cycles, InReady constant 1.
REQ-033 OutReady=0, push ALU=0x10 then 0x20 -> InReady=0 after second accept; third push 0x30 held by source; raise OutReady -> outputs 0x10, 0x20, 0x30 in order, none lost.
REQ-034 FULL state, assert Flush with InValid=1 (ALU=0x99) -> next cycle OutValid=0, OutCtrl=0, InReady=1; 0x99 never appears.
REQ-035 Rst asserted while FULL -> next cycle all outputs zero, OutValid=0; InReady=1 in the cycle after Rst drops.
REQ-036 Simultaneous Accept and Consume in ONE (main ALU=0x5, input 0x6) -> next cycle Out shows 0x6, state ONE, OutValid=1.
